// File: rtl/sum_arbiter_if.sv
// Requester/consumer bundle for the shared-adder arbiter: four operand-pair requesters in, one result out.
// master drives requests and res_ready; slave (the arbiter) drives grants and the result.
interface sum_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic [3:0]         req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_sum;
  logic               res_carry;
  logic [1:0]         res_id;
  logic [7:0]         txn_count;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_carry, res_id, txn_count
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_carry, res_id, txn_count
  );
endinterface

// File: rtl/sum_arbiter.sv
// Round-robin arbiter over four requesters sharing one adder; result registered 1 cycle after accept.
// Grants only when the result slot is empty or being consumed; a stalled result freezes grants and state.
module sum_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sum_arbiter_if.slave  bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [1:0]       id;
  } res_t;

  state_t           state;
  state_t           state_nxt;
  res_t             res_q;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             free;
  logic             accept;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [7:0]       cnt_q;

  // Search starts at ptr so the last winner is visited last.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign free   = (state == EMPTY) || bus.res_ready;
  // rst_n gating keeps grants off for the whole reset assertion.
  assign accept = rst_n && free && found;

  always_comb begin
    bus.req_ready = 4'b0000;
    if (accept) begin
      bus.req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < 4; k++) begin
      if (win == 2'(k)) begin
        a_sel = bus.req_a[k*WIDTH +: WIDTH];
        b_sel = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (bus.res_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      ptr   <= 2'd0;
      cnt_q <= 8'd0;
    end else if (accept) begin
      {res_q.carry, res_q.sum} <= {1'b0, a_sel} + {1'b0, b_sel};
      res_q.id <= win;
      ptr      <= win + 2'd1;
      cnt_q    <= cnt_q + 8'd1;
    end
  end

  assign bus.res_valid = (state == FULL);
  assign bus.res_sum   = res_q.sum;
  assign bus.res_carry = res_q.carry;
  assign bus.res_id    = res_q.id;
  assign bus.txn_count = cnt_q;
endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: directed vectors with literal expectations plus a per-cycle reference model.
module tb_sum_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sum_arbiter_if #(.WIDTH(8)) bus ();

  sum_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers describing what the outputs must be.
  int m_valid;
  int m_sum;
  int m_carry;
  int m_id;
  int m_cnt;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    int w;
    w = -1;
    if (rst_n === 1'b1 && !(m_valid == 1 && bus.res_ready === 1'b0)) begin
      for (int k = 3; k >= 0; k--) begin
        if (bus.req_valid[(m_ptr + k) % 4] === 1'b1) w = (m_ptr + k) % 4;
      end
    end
    return w;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    logic [3:0] r;
    w = winner();
    r = 4'b0000;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    int s;
    if (!rst_n) begin
      m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
    end else begin
      w = winner();
      if (w >= 0) begin
        s       = int'(bus.req_a[w*8 +: 8]) + int'(bus.req_b[w*8 +: 8]);
        m_sum   = s % 256;
        m_carry = (s >= 256) ? 1 : 0;
        m_id    = w;
        m_valid = 1;
        m_cnt   = (m_cnt + 1) % 256;
        m_ptr   = (w + 1) % 4;
      end else if (bus.res_ready === 1'b1) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_req_ready", 32'(bus.req_ready), 32'(exp_ready()));
    check("cmp_res_valid", 32'(bus.res_valid), 32'(m_valid));
    check("cmp_res_sum",   32'(bus.res_sum),   32'(m_sum));
    check("cmp_res_carry", 32'(bus.res_carry), 32'(m_carry));
    check("cmp_res_id",    32'(bus.res_id),    32'(m_id));
    check("cmp_txn_count", 32'(bus.txn_count), 32'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[i]     = 1'b1;
    bus.req_a[i*8 +: 8]  = a;
    bus.req_b[i*8 +: 8]  = b;
  endtask

  task automatic settle_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    #0;
    check(name, act, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
    rst_n         = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_res_valid", 32'(bus.res_valid), 32'h0);
    check("rst_res_sum",   32'(bus.res_sum),   32'h0);
    check("rst_txn_count", 32'(bus.txn_count), 32'h0);
    #10;
    bus.req_valid = 4'b0000;
    rst_n = 1'b1;

    // Single request from requester 2.
    step();
    offer(2, 8'h12, 8'h34);
    #1 check("single_ready", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = 4'b0000;
    #1;
    check("single_sum",   32'(bus.res_sum),   32'h46);
    check("single_carry", 32'(bus.res_carry), 32'h0);
    check("single_id",    32'(bus.res_id),    32'h2);
    check("single_count", 32'(bus.txn_count), 32'h1);
    check("single_valid", 32'(bus.res_valid), 32'h1);

    // Carry out: ptr is 3, requester 0 wins after wrap.
    step();
    offer(0, 8'hFF, 8'h02);
    #1 check("carry_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 4'b0000;
    #1;
    check("carry_sum",   32'(bus.res_sum),   32'h01);
    check("carry_carry", 32'(bus.res_carry), 32'h1);

    // Pointer skip: ptr=1, only requester 0 valid.
    step();
    offer(0, 8'h01, 8'h01);
    #1 check("skip_ready0", 32'(bus.req_ready), 32'h1);
    step();
    offer(0, 8'h02, 8'h02);
    offer(1, 8'h03, 8'h03);
    #1 check("skip_ready1", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid[1] = 1'b0;
    #1 check("skip_id1",    32'(bus.res_id),    32'h1);
    check("skip_ready0b", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 4'b0000;
    #1 check("skip_id0", 32'(bus.res_id), 32'h0);

    // Move ptr to 0 via requester 3, then round-robin with all four valid.
    offer(3, 8'h30, 8'h03);
    step();
    for (int i = 0; i < 4; i++) offer(i, 8'(i * 8'h11), 8'h40);
    for (int c = 0; c < 6; c++) begin
      #1 check("rr_ready", 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (c > 0) check("rr_id", 32'(bus.res_id), 32'((c - 1) % 4));
      step();
    end
    bus.req_valid = 4'b0000;
    #1 check("rr_last_id", 32'(bus.res_id), 32'h1);

    // Backpressure: result held for 5 cycles while requester 1 waits.
    offer(2, 8'h10, 8'h20);
    step();
    bus.req_valid = 4'b0000;
    bus.res_ready = 1'b0;
    offer(1, 8'h05, 8'h07);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      check("bp_sum",   32'(bus.res_sum),   32'h30);
      check("bp_id",    32'(bus.res_id),    32'h2);
      check("bp_valid", 32'(bus.res_valid), 32'h1);
      step();
    end
    bus.res_ready = 1'b1;
    #1 check("bp_release_ready", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = 4'b0000;
    #1;
    check("bp_new_sum",   32'(bus.res_sum),   32'h0C);
    check("bp_new_id",    32'(bus.res_id),    32'h1);
    check("bp_count",     32'(bus.txn_count), 32'd14);
    step();
    check("drain_valid", 32'(bus.res_valid), 32'h0);
    check("drain_hold",  32'(bus.res_sum),   32'h0C);

    // Counter wrap: 242 more accepts reach 256 total.
    for (int n = 0; n < 242; n++) begin
      bus.req_valid = 4'b0000;
      offer(n % 4, 8'(n), 8'(~n));
      step();
    end
    bus.req_valid = 4'b0000;
    #1 check("wrap_count", 32'(bus.txn_count), 32'h0);

    // Async reset in the middle of a stall.
    bus.res_ready = 1'b0;
    offer(1, 8'hAA, 8'hBB);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.res_valid), 32'h0);
    check("arst_sum",   32'(bus.res_sum),   32'h0);
    check("arst_carry", 32'(bus.res_carry), 32'h0);
    check("arst_id",    32'(bus.res_id),    32'h0);
    check("arst_count", 32'(bus.txn_count), 32'h0);
    check("arst_ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    offer(3, 8'h01, 8'h01);
    #1 check("post_rst_ready", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = 4'b0000;
    #1;
    check("post_rst_sum",   32'(bus.res_sum),   32'h65);
    check("post_rst_carry", 32'(bus.res_carry), 32'h1);
    check("post_rst_count", 32'(bus.txn_count), 32'h1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sum_arbiter.md
# sum_arbiter

Round-robin arbiter and sequencer that shares the design's single 8-bit adder datapath among four requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the sum with its carry and requester ID, and holds the result until the downstream consumer accepts it. It sits between the pin-level input decode and `uo_out` in the top-level wrapper.

## Interface
Parameters:
- `WIDTH`, 8: operand and sum width. The requester count is fixed at 4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  4: bit i means requester i presents operands.
- `req_a`  in  4*WIDTH: requester i's operand A is in bits [i*WIDTH +: WIDTH].
- `req_b`  in  4*WIDTH: requester i's operand B, same packing as `req_a`.
- `req_ready`  out  4: one-hot or zero. Bit i means requester i's operands are taken this cycle.
- `res_valid`  out  1: the result register holds an unconsumed result.
- `res_ready`  in  1: the consumer accepts the result this cycle.
- `res_sum`  out  WIDTH: (A + B) mod 2^WIDTH.
- `res_carry`  out  1: carry-out of A + B.
- `res_id`  out  2: index of the requester that produced the result.
- `txn_count`  out  8: count of accepted requests, modulo 256.

## Operation
- Slot free condition: `free = !res_valid || res_ready`. A single output register is used, with no extra buffering.
- Round-robin pointer `ptr` (2 bits):
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first requester with `req_valid` set wins.
- `req_ready[win] = free && |req_valid`. All other bits are 0.
  - `req_ready` is combinational from `req_valid`, `res_valid`, `res_ready` and `ptr`.
  - A requester must not make its `req_valid` depend on its own `req_ready`.
- Accept happens when `req_valid[i] && req_ready[i]`. On the next edge:
  - `{res_carry, res_sum} <= req_a[i] + req_b[i]`, a WIDTH+1 bit add.
  - `res_id <= i`, `res_valid <= 1`.
  - `ptr <= i + 1` (mod 4).
  - `txn_count <= txn_count + 1`. It wraps 255 to 0 with no flag.
- Consume with no new accept (`res_valid && res_ready`, nothing accepted): `res_valid <= 0`. Data outputs hold their last value.
- Simultaneous consume and accept: the new result replaces the old one in the same edge and `res_valid` stays 1. This gives back-to-back throughput of one result per cycle.
- Stall (`res_valid && !res_ready`):
  - `req_ready` is all 0.
  - The result outputs, `ptr` and `txn_count` are frozen.
- No request (`req_valid == 0`): `ptr` is unchanged and no count is added.
- Handshake rule: a requester holds `req_valid`, `req_a` and `req_b` stable until accepted. The arbiter does not drop a pending requester.
- Fairness: a continuously requesting requester is granted within 4 accepts.
- State: two states, EMPTY (`res_valid=0`) and FULL (`res_valid=1`).
  - EMPTY to FULL on accept.
  - FULL to EMPTY on consume without accept.
  - FULL stays FULL on stall, or on consume with accept.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `res_valid=0`, `res_sum=0`, `res_carry=0`, `res_id=0`, `txn_count=0`, `ptr=0`.
  - `req_ready=0` for as long as reset is held.
- Reset mid-operation: any pending result is discarded and nothing is reported.
- The first accept is possible on the first rising edge after `rst_n` deasserts.
- Latency: accept at edge N gives `res_valid` high and data valid after edge N.
- Throughput: 1 result per cycle while `res_ready` is held high.
- Combinational paths: `res_ready` to `req_ready`, and `req_valid` to `req_ready`. There is no combinational path from any input to `res_*`.

## Test plan
- Reset, single request: after reset, requester 2 offers A=0x12, B=0x34 with `res_ready=1`.
  - Expect one cycle of `req_ready=4'b0100`.
  - Next cycle: `res_sum=0x46`, `res_carry=0`, `res_id=2`, `txn_count=1`.
- Carry and wrap: A=0xFF, B=0x02.
  - Expect `res_sum=0x01`, `res_carry=1`.
  - After 256 accepts, expect `txn_count=0`.
- Round-robin: all four requesters hold valid with `res_ready=1`.
  - Expect grant order 0,1,2,3,0,1, one per cycle, with `res_id` following one cycle later.
- Backpressure: produce a result, then drive `res_ready=0` for 5 cycles while requester 1 is valid.
  - Expect `req_ready=0` and the result held stable throughout.
  - On `res_ready=1`, expect requester 1 accepted in that same cycle and its result on the next cycle.
- Pointer skip: `ptr=1` with only requester 0 valid.
  - Expect requester 0 granted and `ptr` becomes 1.
  - Then requesters 0 and 1 both valid: expect requester 1 granted first.
- Async reset mid-stall: with `res_valid=1` and `res_ready=0`, pulse `rst_n` low between clock edges.
  - Expect all outputs at reset values immediately, and `txn_count=0`.
